// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and constants for the QDI flit transmitter
// Contents:
//   state_t      : transmitter FSM states (data phase *_D, spacer phase *_S)
//   RAIL0..RAIL3 : rail index of each 1-of-4 digit value
//   X_LO..Y_HI   : digit positions of the destination fields in the head flit
//   head_digits  : packs dst_x/dst_y into the low four digits of a head flit
package noc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEAD_D,
    HEAD_S,
    DATA_D,
    DATA_S,
    EOF_D,
    EOF_S
  } state_t;

  localparam int RAIL0 = 0;
  localparam int RAIL1 = 1;
  localparam int RAIL2 = 2;
  localparam int RAIL3 = 3;

  localparam int X_LO = 0;
  localparam int X_HI = 1;
  localparam int Y_LO = 2;
  localparam int Y_HI = 3;

  // Head flit value: remaining digits are zero, i.e. rail 0 high after encoding.
  function automatic logic [7:0] head_digits(input logic [3:0] dx, input logic [3:0] dy);
    logic [7:0] h;
    h = '0;
    h[2*X_LO +: 2] = dx[1:0];
    h[2*X_HI +: 2] = dx[3:2];
    h[2*Y_LO +: 2] = dy[1:0];
    h[2*Y_HI +: 2] = dy[3:2];
    return h;
  endfunction

endpackage

// File: rtl/ni_tx_if.sv
// rtl/ni_tx_if.sv - payload word handshake between a word source and ni_tx
// Signals:
//   in_valid/in_ready : word handshake, transfer when both high at a clk edge
//   in_data, in_last  : payload word and end-of-frame marker
//   dst_x, dst_y      : destination, only meaningful on the first word of a frame
// Modports: master = word source, slave = ni_tx.
interface ni_tx_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [3:0]    dst_x;
  logic [3:0]    dst_y;

  modport master (output in_valid, in_data, in_last, dst_x, dst_y, input in_ready);
  modport slave  (input in_valid, in_data, in_last, dst_x, dst_y, output in_ready);
endinterface

// File: rtl/ni_tx_dr_enc.sv
// rtl/ni_tx_dr_enc.sv - combinational binary to 1-of-4 digit encoder
// Ports:
//   word   : 2*SCN-bit binary value, digit k is word[2k+1:2k]
//   r0..r3 : rail k of each output is high iff digit k equals the rail index
module dr_enc
  import noc_pkg::*;
#(
  parameter int SCN = 8
) (
  input  logic [2*SCN-1:0] word,
  output logic [SCN-1:0]   r0,
  output logic [SCN-1:0]   r1,
  output logic [SCN-1:0]   r2,
  output logic [SCN-1:0]   r3
);

  logic [3:0] oh;

  always_comb begin
    r0 = '0;
    r1 = '0;
    r2 = '0;
    r3 = '0;
    oh = '0;
    for (int k = 0; k < SCN; k++) begin
      oh    = 4'b0001 << word[2*k +: 2];
      r0[k] = oh[RAIL0];
      r1[k] = oh[RAIL1];
      r2[k] = oh[RAIL2];
      r3[k] = oh[RAIL3];
    end
  end

endmodule

// File: rtl/ni_tx.sv
// rtl/ni_tx.sv - synchronous word source to 5-rail four-phase QDI flit channel
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   up          : word handshake (ni_tx_if slave)
//   o0..o3      : 1-of-4 data rails, one bit per digit
//   o4          : eof rail
//   ia          : asynchronous channel ack from the router
//   busy        : frame in progress
//   frame_done  : one-cycle pulse when the EOF handshake completes
module ni_tx
  import noc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SCN  = DW/2,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ni_tx_if.slave         up,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           ia,
  output logic           busy,
  output logic           frame_done
);

  state_t          state;
  logic [SYNC-1:0] ack_sync;
  logic [SYNC-2:0] warm;
  logic            ack_s;
  logic            ack_nxt;
  logic [DW-1:0]   data_q;
  logic            last_q;
  logic            rdy_q;
  logic [DW-1:0]   enc_in;
  logic [SCN-1:0]  e0, e1, e2, e3;

  assign ack_s       = ack_sync[SYNC-1];
  // ack_s as it will be after the coming edge; lets in_ready be a flop that
  // still equals ~ack_s in the cycle it is presented.
  assign ack_nxt     = ack_sync[SYNC-2];
  assign up.in_ready = rdy_q;

  // Encoder input is whatever the next data phase will show: the head built
  // from the live destination in IDLE, the live word in DATA_S, else the held word.
  // The destination needs no holding register because the head rails hold it.
  always_comb begin
    enc_in = data_q;
    if (state == IDLE)
      enc_in = DW'(head_digits(up.dst_x, up.dst_y));
    else if (state == DATA_S)
      enc_in = up.in_data;
  end

  dr_enc #(.SCN(SCN)) u_enc (
    .word (enc_in),
    .r0   (e0),
    .r1   (e1),
    .r2   (e2),
    .r3   (e3)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_sync   <= '0;
      warm       <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      rdy_q      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      o0         <= '0;
      o1         <= '0;
      o2         <= '0;
      o3         <= '0;
      o4         <= 1'b0;
    end else begin
      ack_sync   <= {ack_sync[SYNC-2:0], ia};
      // Shifts in ones; the top bit marks that the synchroniser now carries
      // post-reset samples of ia, so an ack still high from before reset is seen.
      warm       <= ~(~warm << 1);
      frame_done <= 1'b0;
      rdy_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (up.in_valid && rdy_q) begin
            data_q <= up.in_data;
            last_q <= up.in_last;
            o0     <= e0;
            o1     <= e1;
            o2     <= e2;
            o3     <= e3;
            busy   <= 1'b1;
            state  <= HEAD_D;
          end else begin
            rdy_q <= ~ack_nxt & warm[SYNC-2];
          end
        end
        HEAD_D: if (ack_s) begin
          {o3, o2, o1, o0} <= '0;
          state            <= HEAD_S;
        end
        HEAD_S: if (!ack_s) begin
          o0    <= e0;
          o1    <= e1;
          o2    <= e2;
          o3    <= e3;
          state <= DATA_D;
        end
        DATA_D: if (ack_s) begin
          {o3, o2, o1, o0} <= '0;
          rdy_q            <= ~ack_nxt & ~last_q;
          state            <= DATA_S;
        end
        DATA_S: begin
          if (!ack_s && last_q) begin
            o4    <= 1'b1;
            state <= EOF_D;
          end else if (up.in_valid && rdy_q) begin
            // rdy_q high here already implies ack_s low and no last pending.
            data_q <= up.in_data;
            last_q <= up.in_last;
            o0     <= e0;
            o1     <= e1;
            o2     <= e2;
            o3     <= e3;
            state  <= DATA_D;
          end else begin
            rdy_q <= ~ack_nxt & ~last_q;
          end
        end
        EOF_D: if (ack_s) begin
          o4    <= 1'b0;
          state <= EOF_S;
        end
        EOF_S: if (!ack_s) begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          rdy_q      <= ~ack_nxt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_tx.sv
// tb/tb_ni_tx.sv - self-checking bench for ni_tx with a QDI receiver model
module tb_ni_tx;

  localparam int DW   = 16;
  localparam int SCN  = 8;
  localparam int SYNC = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ia;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic           o4;
  logic           busy;
  logic           frame_done;

  always #5 clk = ~clk;

  ni_tx_if #(.DW(DW)) bus ();

  ni_tx #(.DW(DW), .SCN(SCN), .SYNC(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (bus),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .o4         (o4),
    .ia         (ia),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Reference view of the synchronised ack.
  logic [SYNC-1:0] hist;
  always @(posedge clk) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[SYNC-2:0], ia};
  end

  int          tests = 0;
  int          fails = 0;
  logic [16:0] exp_q[$];
  logic [32:0] tok_hist[$];
  logic [32:0] prev_r;
  bit          chk_en, rx_en, rx_rand;
  int          rx_dly, rx_fix, rx_cnt, rx_tokens, fd_cnt;
  logic [15:0] wbuf[8];
  int          f0;

  function automatic logic [32:0] rails();
    return {o4, o3, o2, o1, o0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle_checks();
    logic [32:0] r;
    int bad;
    r   = rails();
    bad = 0;
    for (int k = 0; k < SCN; k++)
      if ((int'(o0[k]) + int'(o1[k]) + int'(o2[k]) + int'(o3[k])) > 1) bad++;
    chk("rails_known", 64'($isunknown(r)), 0);
    chk("digit_onehot", 64'(bad), 0);
    chk("eof_excl", 64'(o4 & (|r[31:0])), 0);
    chk("rdy_spacer", 64'(bus.in_ready & ((|r) | hist[SYNC-1])), 0);
    chk("data_spacer_only", 64'((prev_r != 0) && (r != 0) && (prev_r != r)), 0);
    prev_r = r;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic rx_step();
    logic [32:0] r;
    logic [16:0] got, exp;
    int inc;
    if (!rx_en) return;
    r = rails();
    if (ia == 1'b0) begin
      if (r != 0) begin
        if (rx_cnt >= rx_dly) begin
          got = '0;
          inc = 0;
          if (o4) got = {1'b1, 16'h0};
          else begin
            for (int k = 0; k < SCN; k++)
              case ({o3[k], o2[k], o1[k], o0[k]})
                4'b0001: got[2*k +: 2] = 2'd0;
                4'b0010: got[2*k +: 2] = 2'd1;
                4'b0100: got[2*k +: 2] = 2'd2;
                4'b1000: got[2*k +: 2] = 2'd3;
                default: inc++;
              endcase
            chk("tok_complete", 64'(inc), 0);
          end
          tok_hist.push_back(r);
          rx_tokens++;
          chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk("token", 64'(got), 64'(exp));
          end
          ia     = 1'b1;
          rx_cnt = 0;
          rx_dly = rx_rand ? int'($urandom_range(0, 4)) : rx_fix;
        end else rx_cnt++;
      end
    end else begin
      if (r == 0) begin
        if (rx_cnt >= rx_dly) begin
          ia     = 1'b0;
          rx_cnt = 0;
          rx_dly = rx_rand ? int'($urandom_range(0, 4)) : rx_fix;
        end else rx_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) cycle_checks();
    rx_step();
  endtask

  task automatic put_word(input logic [15:0] d, input logic l, input logic [3:0] dx, input logic [3:0] dy);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.dst_x    = dx;
    bus.dst_y    = dy;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(n < 3000), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic send_frame(input logic [3:0] dx, input logic [3:0] dy, input int n, input int gap_at);
    int t0, nz;
    t0 = rx_tokens;
    exp_q.push_back({1'b0, 8'h00, dy, dx});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, wbuf[i]});
    exp_q.push_back({1'b1, 16'h0});
    for (int i = 0; i < n; i++) begin
      put_word(wbuf[i], i == n - 1, (i == 0) ? dx : 4'($urandom), (i == 0) ? dy : 4'($urandom));
      if (i == gap_at) begin
        nz = 0;
        for (int g = 0; g < 20; g++) begin
          tick();
          if (g >= 12 && rails() != 0) nz++;
        end
        chk("gap_spacer", 64'(nz), 0);
        chk("gap_tokens", 64'(rx_tokens - t0), 64'(gap_at + 2));
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_wait", 64'(n < 5000), 1);
    chk("sb_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_rails(input bit nz);
    int n;
    n = 0;
    while (((rails() != 0) != nz) && n < 200) begin
      tick();
      n++;
    end
    chk("rails_wait", 64'(n < 200), 1);
  endtask

  initial begin
    rst_n = 1'b0; ia = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.dst_x = '0; bus.dst_y = '0;
    rx_en = 0; rx_rand = 0; rx_fix = 3; rx_dly = 3; rx_cnt = 0; rx_tokens = 0; fd_cnt = 0;
    prev_r = '0; chk_en = 0;
    tick(); tick();
    chk_en = 1;
    chk("rst_rails", 64'(rails()), 0);
    chk("rst_ready", 64'(bus.in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_frame_done", 64'(frame_done), 0);
    rst_n = 1'b1; rx_en = 1;
    tick();

    // single-word frame, dst (2,3), receiver acks after 3 cycles
    tok_hist.delete(); f0 = fd_cnt;
    wbuf[0] = 16'h0000;
    send_frame(4'h2, 4'h3, 1, -1);
    wait_idle();
    chk("t1_ntok", 64'(tok_hist.size()), 3);
    chk("t1_head_rails", 64'(tok_hist[0]), 64'({1'b0, 8'h04, 8'h01, 8'h00, 8'hFA}));
    chk("t1_data_rails", 64'(tok_hist[1]), 64'({1'b0, 8'h00, 8'h00, 8'h00, 8'hFF}));
    chk("t1_eof_rails", 64'(tok_hist[2]), 64'({1'b1, 32'h0}));
    chk("t1_frame_done", 64'(fd_cnt - f0), 1);
    chk("t1_busy", 64'(busy), 0);

    // three-word frame
    rx_fix = 2;
    tok_hist.delete(); f0 = fd_cnt;
    wbuf[0] = 16'h1B1B; wbuf[1] = 16'hE4E4; wbuf[2] = 16'hFFFF;
    send_frame(4'h5, 4'hA, 3, -1);
    wait_idle();
    chk("t2_ntok", 64'(tok_hist.size()), 5);
    chk("t2_1b1b_rails", 64'(tok_hist[1]), 64'({1'b0, 8'h11, 8'h22, 8'h44, 8'h88}));
    chk("t2_e4e4_rails", 64'(tok_hist[2]), 64'({1'b0, 8'h88, 8'h44, 8'h22, 8'h11}));
    chk("t2_ffff_rails", 64'(tok_hist[3]), 64'({1'b0, 8'hFF, 8'h00, 8'h00, 8'h00}));
    chk("t2_frame_done", 64'(fd_cnt - f0), 1);

    // in_valid dropped for 20 cycles after the second word
    tok_hist.delete(); f0 = fd_cnt;
    for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
    send_frame(4'h1, 4'h1, 4, 1);
    wait_idle();
    chk("t3_ntok", 64'(tok_hist.size()), 6);
    chk("t3_frame_done", 64'(fd_cnt - f0), 1);

    // ia held high across reset release
    rx_en = 0;
    rst_n = 1'b0; ia = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 8'h00, 4'h8, 4'h7});
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'h0});
    bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_last = 1'b1; bus.dst_x = 4'h7; bus.dst_y = 4'h8;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_ready_held", 64'(bus.in_ready), 0);
      chk("t4_no_token", 64'(rails()), 0);
    end
    ia = 1'b0;
    for (int i = 0; i < SYNC - 1; i++) begin
      tick();
      chk("t4_sync_wait", 64'(bus.in_ready), 0);
    end
    tick();
    chk("t4_sync_ready", 64'(bus.in_ready), 1);
    rx_en = 1; rx_cnt = 0;
    tick();
    bus.in_valid = 1'b0;
    f0 = fd_cnt;
    wait_idle();
    chk("t4_frame_done", 64'(fd_cnt - f0), 1);

    // reset while a payload token is on the rails
    rx_en = 0; ia = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'hA5A5; bus.in_last = 1'b0; bus.dst_x = 4'h3; bus.dst_y = 4'hC;
    begin
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin tick(); n++; end
      chk("t5_accept_wait", 64'(n < 100), 1);
    end
    tick();
    bus.in_valid = 1'b0;
    chk("t5_head_on", 64'(rails() != 0), 1);
    ia = 1'b1;
    wait_rails(0);
    ia = 1'b0;
    wait_rails(1);
    chk("t5_data_rails", 64'(rails()), 64'({1'b0, 8'h00, 8'hCC, 8'h33, 8'h00}));
    rst_n = 1'b0;
    tick();
    chk("t5_rst_rails", 64'(rails()), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_ready", 64'(bus.in_ready), 0);
    tick();
    rst_n = 1'b1;
    rx_en = 1; rx_cnt = 0;
    tick();
    f0 = fd_cnt;
    wbuf[0] = 16'h5A5A; wbuf[1] = 16'h0F0F;
    send_frame(4'hE, 4'h6, 2, -1);
    wait_idle();
    chk("t5_after_frame_done", 64'(fd_cnt - f0), 1);

    // random frames against a random-delay receiver
    rx_rand = 1;
    f0 = fd_cnt;
    for (int f = 0; f < 200; f++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) wbuf[i] = 16'($urandom);
      send_frame(4'($urandom), 4'($urandom), len, -1);
    end
    wait_idle();
    chk("t6_frame_done", 64'(fd_cnt - f0), 200);
    chk("t6_busy", 64'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ni_tx.md
Name: ni_tx

Overview:
- Synchronous-to-QDI flit transmitter: the network-interface injection end feeding a router local input port.
- Accepts words on a valid/ready interface and builds a frame: head flit carrying the destination, then payload flits, then one EOF token.
- Drives the 5-rail (1-of-4 plus eof) four-phase return-to-zero channel with a single channel-level ack. Channel slicing is disabled.

Parameters:
DW, 16, data width in bits; even, >=8
SCN, DW/2, number of 1-of-4 digits per flit
SYNC, 2, number of flops synchronising ia into clk; >=2

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  payload word valid
in_ready  output  1  payload word accepted when in_valid&in_ready at a clk edge
in_data  input  DW  payload word
in_last  input  1  word is the last payload of its frame
dst_x  input  4  destination x, sampled with the first word of a frame
dst_y  input  4  destination y, sampled with the first word of a frame
o0  output  SCN  rail 0 of each digit
o1  output  SCN  rail 1 of each digit
o2  output  SCN  rail 2 of each digit
o3  output  SCN  rail 3 of each digit
o4  output  1  eof rail
ia  input  1  asynchronous channel ack from the router
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when the EOF token handshake completes

Behaviour:
- Reset: all outputs are driven by flops, taking effect on the first clk edge with rst_n=0.
  - o0..o4 = 0 (spacer); in_ready=0; busy=0; frame_done=0.
  - Synchroniser flops = 0; FSM = IDLE; holding register cleared.
- Ack: ia passes through a SYNC-flop synchroniser to give ack_s. All handshake decisions use ack_s only.
- Encoding: digit k of word w drives rail r high iff w[2k+1:2k]==r. Exactly one of o0[k]..o3[k] is high per valid data token. Spacer = all rails 0.
- EOF token: o4=1, o0..o3=0.
- Head flit:
  - digit0 = dst_x[1:0], digit1 = dst_x[3:2]
  - digit2 = dst_y[1:0], digit3 = dst_y[3:2]
  - digits 4..SCN-1 encode value 0 (rail 0 high)
- Outputs change only from flop Q. Data to spacer and spacer to data are the only transitions. No output combinational logic, so outputs are glitch-free.
- FSM:
  - IDLE:
    - in_ready = ~ack_s.
    - On accept: latch in_data, in_last, dst_x, dst_y; busy=1; go HEAD_D.
    - If ack_s=1 (e.g. ia still high after reset), hold in_ready=0 until ack_s=0.
  - HEAD_D: drive head flit. On ack_s=1 go HEAD_S.
  - HEAD_S: drive spacer. On ack_s=0 go DATA_D.
  - DATA_D: drive the latched word. On ack_s=1 go DATA_S.
  - DATA_S: drive spacer; in_ready = ~ack_s & ~last_latched. On ack_s=0:
    - if last_latched, go EOF_D;
    - else if in_valid, latch and go DATA_D;
    - else stay in DATA_S (spacer held).
  - EOF_D: drive EOF token. On ack_s=1 go EOF_S.
  - EOF_S: drive spacer. On ack_s=0: pulse frame_done, busy=0, go IDLE.
- Latency:
  - Accept to head flit on rails: 1 cycle.
  - Each phase waits at least SYNC cycles after an ia edge.
  - Minimum frame length = head + 1 payload + EOF.
- in_last on the first word gives a frame of one payload flit.
- in_valid deasserted mid-frame: the channel idles in spacer with no timeout.
- in_valid while ack_s=1 in IDLE or DATA_S: not accepted; in_ready=0.
- dst_x/dst_y are ignored except on the first word of a frame.
- Reset mid-frame: outputs return to spacer on the next edge and the frame is abandoned. The router side must also be reset.
- in_data and in_last must be held stable while in_valid=1 and in_ready=0.

Decomposition:
- Shared package noc_pkg:
  - FSM state enum (IDLE, HEAD_D, HEAD_S, DATA_D, DATA_S, EOF_D, EOF_S)
  - rail index constants
  - head-flit digit positions (X_LO=0, X_HI=1, Y_LO=2, Y_HI=3)
- Sub-module dr_enc: purely combinational 2-bit-per-digit binary to 1-of-4 encoder, SCN digits, instantiated once.

Test Plan:
- Reset with ia=0, then frame dst_x=4'h2, dst_y=4'h3, one word 16'h0000 with last, router model acking after 3 cycles:
  - head digits: o2[0], o0[1], o3[2], o0[3], o0[7:4] high;
  - then payload all o0;
  - then o4=1;
  - frame_done pulses once; busy falls.
- Three-word frame 16'h1B1B, 16'hE4E4, 16'hFFFF:
  - word 16'h1B1B gives per-digit rails 3,2,1,0,3,2,1,0 (digit0..7);
  - every token is separated by spacer;
  - in_ready is high only in DATA_S with ack_s=0.
- in_valid dropped for 20 cycles mid-frame: rails stay all 0, no extra tokens, frame then resumes and completes with a single EOF.
- ia held high across reset release: no token is emitted and in_ready=0 until ia falls plus SYNC cycles.
- rst_n asserted while in DATA_D: o0..o4=0 on the next edge, busy=0, in_ready=0. A new frame after release is transmitted correctly.
- Random 200 frames (lengths 1..8) against a random-delay QDI receiver model: decoded destination and payload match the sent values.
  - Checker asserts one-hot-or-zero per digit on every cycle.
  - Checker asserts o4 is never high together with any data rail.
